// File: rtl/lab1_sweep_pkg.sv
// Shared state type, sizing constants and vector-to-drive mapping for the lab1 sweep controller.
package lab1_sweep_pkg;

    localparam int IDX_W   = 4;
    localparam int NUM_VEC = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } sweep_state_t;

    // Datapath inputs are active-low: vector idx is presented as its complement on {e,u,t,g}.
    function automatic logic [3:0] vec_drive(input logic [IDX_W-1:0] idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/lab1_sweep_settle_tmr.sv
// Settle-time counter: clears on request, counts while enabled, flags the terminal count.
module lab1_sweep_settle_tmr
    import lab1_sweep_pkg::*;
#(
    parameter int WIDTH = IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic             tc
);

    logic [WIDTH-1:0] cnt;

    // NOTE: registered state is always written with <=; mixing in = here would race the readers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/lab1_sweep_ctrl.sv
// Sweeps a 4-input lab datapath through all 16 vectors and captures its X/Y truth table.
// Define LAB1_SWEEP_CHECK_EN to compare captures against EXP_X/EXP_Y and record the first failure.
module lab1_sweep_ctrl
    import lab1_sweep_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] EXP_X         = 16'h0000,
    parameter logic [15:0] EXP_Y         = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             x_in,
    input  logic             y_in,
    output logic             g,
    output logic             t,
    output logic             u,
    output logic             e,
    output logic             busy,
    output logic             done,
    output logic [15:0]      table_x,
    output logic [15:0]      table_y,
    output logic             mismatch,
    output logic [IDX_W-1:0] fail_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VEC - 1);
    localparam logic [IDX_W-1:0] SETTLE_TC = IDX_W'(SETTLE_CYCLES - 1);

    sweep_state_t     state, next_state;
    logic [IDX_W-1:0] idx;
    logic             settle_tc;
    logic             sampling;

    assign sampling = (state == SAMPLE) && !abort;

    lab1_sweep_settle_tmr #(
        .WIDTH (IDX_W)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != SETTLE),
        .en    (state == SETTLE),
        .term  (SETTLE_TC),
        .tc    (settle_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default before any branch, so no path can infer a latch.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = SETTLE;
                SETTLE:  if (settle_tc) next_state = SAMPLE;
                SAMPLE:  next_state = (idx == LAST_IDX) ? DONE : SETTLE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // idx only advances on SAMPLE -> SETTLE, so the drives hold steady through each sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (next_state == IDLE) begin
            idx <= '0;
        end else if (sampling && (idx != LAST_IDX)) begin
            idx <= idx + IDX_W'(1);
        end
    end

    // NOTE: the tables survive start and abort on purpose; only rst_n clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            table_x <= '0;
            table_y <= '0;
        end else if (sampling) begin
            table_x[idx] <= x_in;
            table_y[idx] <= y_in;
        end
    end

    assign {e, u, t, g} = vec_drive(idx);
    assign busy         = (state == SETTLE) || (state == SAMPLE);
    assign done         = (state == DONE);

`ifdef LAB1_SWEEP_CHECK_EN
    logic accept;
    logic vec_bad;

    assign accept  = (state == IDLE) && start && !abort;
    assign vec_bad = (x_in != EXP_X[idx]) || (y_in != EXP_Y[idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch <= 1'b0;
            fail_idx <= '0;
        end else if (accept) begin
            mismatch <= 1'b0;
            fail_idx <= '0;
        end else if (sampling && vec_bad && !mismatch) begin
            mismatch <= 1'b1;
            fail_idx <= idx;
        end
    end
`else
    logic unused_exp;

    assign unused_exp = ^{EXP_X, EXP_Y};
    assign mismatch   = 1'b0;
    assign fail_idx   = '0;
`endif

endmodule

// File: tb/tb_lab1_sweep_ctrl.sv
// Scoreboard bench for lab1_sweep_ctrl: random truth tables, abort, repeat-start, reset and fast-settle sweeps.
module tb_lab1_sweep_ctrl;

    localparam logic [15:0] EXP_X_P = 16'h5555;
    localparam logic [15:0] EXP_Y_P = 16'h000F;

    typedef struct {
        int          done_cyc;
        logic [15:0] tx;
        logic [15:0] ty;
        logic        mm;
        logic [3:0]  fi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        x_in, y_in;
    logic        g, t, u, e, busy, done, mismatch;
    logic [15:0] table_x, table_y;
    logic [3:0]  fail_idx;

    logic        start1 = 1'b0;
    logic        abort1 = 1'b0;
    logic        x_in1, y_in1;
    logic        g1, t1, u1, e1, busy1, done1, mismatch1;
    logic [15:0] table_x1, table_y1;
    logic [3:0]  fail_idx1;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          use_tbl = 1'b0;
    logic [15:0] fx = '0;
    logic [15:0] fy = '0;
    logic [15:0] model_tx = '0;
    logic [15:0] model_ty = '0;
    exp_t        sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Lab datapath: either the reference circuit X=g, Y=e&u, or an arbitrary truth table indexed by vector.
    function automatic logic dp_x(input logic [3:0] drv, input bit tbl, input logic [15:0] f);
        logic [3:0] i;
        i = ~drv;
        return tbl ? f[i] : drv[0];
    endfunction

    function automatic logic dp_y(input logic [3:0] drv, input bit tbl, input logic [15:0] f);
        logic [3:0] i;
        i = ~drv;
        return tbl ? f[i] : (drv[3] & drv[2]);
    endfunction

    assign x_in  = dp_x({e, u, t, g}, use_tbl, fx);
    assign y_in  = dp_y({e, u, t, g}, use_tbl, fy);
    assign x_in1 = dp_x({e1, u1, t1, g1}, use_tbl, fx);
    assign y_in1 = dp_y({e1, u1, t1, g1}, use_tbl, fy);

    lab1_sweep_ctrl #(
        .SETTLE_CYCLES (2),
        .EXP_X         (EXP_X_P),
        .EXP_Y         (EXP_Y_P)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x_in(x_in), .y_in(y_in),
        .g(g), .t(t), .u(u), .e(e), .busy(busy), .done(done),
        .table_x(table_x), .table_y(table_y), .mismatch(mismatch), .fail_idx(fail_idx)
    );

    lab1_sweep_ctrl #(
        .SETTLE_CYCLES (1),
        .EXP_X         (EXP_X_P),
        .EXP_Y         (EXP_Y_P)
    ) dut_s1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .x_in(x_in1), .y_in(y_in1),
        .g(g1), .t(t1), .u(u1), .e(e1), .busy(busy1), .done(done1),
        .table_x(table_x1), .table_y(table_y1), .mismatch(mismatch1), .fail_idx(fail_idx1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_start(output int k);
        k = cyc + 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Expected outcome of a full sweep accepted at edge k: apply every vector to the datapath model.
    task automatic push_sweep(input int k, input int settle);
        exp_t        it;
        logic [3:0]  drv;
        logic [15:0] ex, ey;
        ex = EXP_X_P;
        ey = EXP_Y_P;
        it.done_cyc = k + 16 * (settle + 1);
        it.mm = 1'b0;
        it.fi = '0;
        for (int i = 0; i < 16; i++) begin
            drv = ~4'(i);
            it.tx[i] = dp_x(drv, use_tbl, fx);
            it.ty[i] = dp_y(drv, use_tbl, fy);
`ifdef LAB1_SWEEP_CHECK_EN
            if (!it.mm && ((it.tx[i] != ex[i]) || (it.ty[i] != ey[i]))) begin
                it.mm = 1'b1;
                it.fi = 4'(i);
            end
`endif
        end
        model_tx = it.tx;
        model_ty = it.ty;
        sb_q.push_back(it);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expected sweep.
    always @(negedge clk) begin : monitor
        exp_t it;
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                it = sb_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(it.done_cyc));
                check("busy_at_done", 32'(busy), 32'd0);
                check("table_x", 32'(table_x), 32'(it.tx));
                check("table_y", 32'(table_y), 32'(it.ty));
                check("mismatch", 32'(mismatch), 32'(it.mm));
                check("fail_idx", 32'(fail_idx), 32'(it.fi));
            end
        end
    end

    initial begin : stim
        int          k;
        logic [3:0]  v;
        logic [15:0] m;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_drive", 32'({e, u, t, g}), 32'hF);
        check("rst_table_x", 32'(table_x), 32'd0);
        check("rst_table_y", 32'(table_y), 32'd0);
        check("rst_mismatch", 32'(mismatch), 32'd0);
        check("rst_fail_idx", 32'(fail_idx), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reference circuit sweep with per-vector drive and timing checks.
        use_tbl = 1'b0;
        pulse_start(k);
        push_sweep(k, 2);
        for (int i = 0; i < 16; i++) begin
            v = ~4'(i);
            wait_until(k + 3 * i);
            check("drive_settle", 32'({e, u, t, g}), 32'(v));
            check("busy_settle", 32'(busy), 32'd1);
            wait_until(k + 3 * i + 2);
            check("drive_sample", 32'({e, u, t, g}), 32'(v));
        end
        wait_until(k + 48);
        check("busy_end", 32'(busy), 32'd0);
        wait_until(k + 49);
        check("done_width", 32'(done), 32'd0);
        check("drive_idle", 32'({e, u, t, g}), 32'hF);

        // Random truth tables, plus one whose Y first departs from the reference at vector 4.
        use_tbl = 1'b1;
        for (int r = 0; r < 5; r++) begin
            fx = (r == 4) ? 16'h5555 : 16'($urandom);
            fy = (r == 4) ? 16'h001F : 16'($urandom);
            pulse_start(k);
            push_sweep(k, 2);
            wait_until(k + 50);
        end

        // abort and start together in IDLE: stays idle.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("abort_start_idle2", 32'(busy), 32'd0);

        // abort in cycle 10: vectors 0..2 captured, the rest of the table retained.
        fx = 16'($urandom);
        fy = 16'($urandom);
        pulse_start(k);
        wait_until(k + 9);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_drive", 32'({e, u, t, g}), 32'hF);
        model_tx = (model_tx & ~16'h0007) | (fx & 16'h0007);
        model_ty = (model_ty & ~16'h0007) | (fy & 16'h0007);
        wait_until(k + 60);
        check("abort_table_x", 32'(table_x), 32'(model_tx));
        check("abort_table_y", 32'(table_y), 32'(model_ty));

        // start held high: back-to-back sweeps with exactly one IDLE cycle between.
        fx = 16'($urandom);
        fy = 16'($urandom);
        k = cyc + 1;
        start = 1'b1;
        push_sweep(k, 2);
        push_sweep(k + 50, 2);
        wait_until(k + 48);
        check("held_busy_done", 32'(busy), 32'd0);
        wait_until(k + 49);
        check("held_idle_busy", 32'(busy), 32'd0);
        check("held_idle_done", 32'(done), 32'd0);
        wait_until(k + 50);
        check("held_restart", 32'(busy), 32'd1);
        start = 1'b0;
        wait_until(k + 99);
        check("held_stop", 32'(busy), 32'd0);
        wait_until(k + 102);
        check("held_stop2", 32'(busy), 32'd0);

        // Reset at cycle 20 of a sweep, then a clean full sweep.
        fx = 16'($urandom);
        fy = 16'($urandom);
        pulse_start(k);
        wait_until(k + 19);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_drive", 32'({e, u, t, g}), 32'hF);
        check("mid_rst_table_x", 32'(table_x), 32'd0);
        check("mid_rst_table_y", 32'(table_y), 32'd0);
        check("mid_rst_mismatch", 32'(mismatch), 32'd0);
        check("mid_rst_fail_idx", 32'(fail_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fx = 16'($urandom);
        fy = 16'($urandom);
        pulse_start(k);
        push_sweep(k, 2);
        wait_until(k + 50);

        // SETTLE_CYCLES=1 instance: two cycles per vector, done in cycle 33.
        fx = 16'($urandom);
        fy = 16'($urandom);
        k = cyc + 1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v = ~4'(i);
            m = 16'((32'd2 << i) - 32'd1);
            wait_until(k + 2 * i + 1);
            check("s1_drive_sample", 32'({e1, u1, t1, g1}), 32'(v));
            wait_until(k + 2 * i + 2);
            check("s1_table_x", 32'(table_x1), 32'(fx & m));
            check("s1_table_y", 32'(table_y1), 32'(fy & m));
        end
        wait_until(k + 32);
        check("s1_done", 32'(done1), 32'd1);
        check("s1_busy_end", 32'(busy1), 32'd0);
        wait_until(k + 33);
        check("s1_done_width", 32'(done1), 32'd0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
